// File: rtl/microwave_ctrl.sv
// Cooking sequencer: keypad digit entry, timer-chain load/clear, tick generation,
// magnetron control, pause/cancel and completion hold. Every output is a flop.
module microwave_ctrl #(
  parameter int TICK_DIV    = 100,
  parameter int DONE_CYCLES = 300
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  input  logic       tmr_zero,
  output logic       tmr_load_n,
  output logic       tmr_clr_n,
  output logic       tmr_en,
  output logic [3:0] sec_u,
  output logic [3:0] sec_t,
  output logic [3:0] min_u,
  output logic       mag_on,
  output logic       done,
  output logic [2:0] state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES + 1) : 1;
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] HOLD_MAX = DW'(DONE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_LOAD  = 3'd2,
    S_COOK  = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        r_state, w_state_nx;
  logic [3:0]    r_sec_u, r_sec_t, r_min_u;
  logic [3:0]    w_sec_u_nx, w_sec_t_nx, w_min_u_nx;
  logic [PW-1:0] r_pre, w_pre_nx;
  logic [DW-1:0] r_hold, w_hold_nx;
  logic          r_load_n, r_clr_n, r_en, r_mag, r_done;
  logic          w_en_nx, w_clr_n_nx;
  logic          w_key_ok, w_digits_nz, w_entry_ok;

  assign w_key_ok    = key_valid && (key_digit <= 4'd9);
  assign w_digits_nz = |{r_min_u, r_sec_t, r_sec_u};
  assign w_entry_ok  = door_closed && (r_sec_t <= 4'd5) && w_digits_nz;

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    w_state_nx = r_state;
    w_sec_u_nx = r_sec_u;
    w_sec_t_nx = r_sec_t;
    w_min_u_nx = r_min_u;
    w_pre_nx   = r_pre;
    w_hold_nx  = r_hold;
    w_en_nx    = 1'b0;
    w_clr_n_nx = 1'b1;

    unique case (r_state)
      S_IDLE, S_ENTRY: begin
        if (stop) begin
          w_state_nx = S_IDLE;
          {w_min_u_nx, w_sec_t_nx, w_sec_u_nx} = '0;
          w_clr_n_nx = 1'b0;
        end else if (start && door_closed && (r_state == S_IDLE)) begin
          // Quick start from an empty entry always cooks 0:30.
          w_state_nx = S_LOAD;
          w_min_u_nx = 4'd0;
          w_sec_t_nx = 4'd3;
          w_sec_u_nx = 4'd0;
        end else if (start && (r_state == S_ENTRY) && w_entry_ok) begin
          w_state_nx = S_LOAD;
        end else if (w_key_ok) begin
          w_state_nx = S_ENTRY;
          w_min_u_nx = r_sec_t;
          w_sec_t_nx = r_sec_u;
          w_sec_u_nx = key_digit;
        end
      end

      S_LOAD: begin
        w_state_nx = S_COOK;
        w_pre_nx   = PRE_MAX;
      end

      S_COOK: begin
        if (stop || !door_closed) begin
          w_state_nx = S_PAUSE;
        end else if (tmr_zero) begin
          w_state_nx = S_DONE;
          w_hold_nx  = HOLD_MAX;
        end else if (r_pre == '0) begin
          w_pre_nx = PRE_MAX;
          w_en_nx  = 1'b1;
        end else begin
          w_pre_nx = r_pre - PW'(1);
        end
      end

      S_PAUSE: begin
        if (stop) begin
          w_state_nx = S_IDLE;
          {w_min_u_nx, w_sec_t_nx, w_sec_u_nx} = '0;
          w_clr_n_nx = 1'b0;
        end else if (start && door_closed) begin
          w_state_nx = S_COOK;
        end
      end

      S_DONE: begin
        if (stop || !door_closed || (r_hold == '0)) begin
          w_state_nx = S_IDLE;
          {w_min_u_nx, w_sec_t_nx, w_sec_u_nx} = '0;
          w_clr_n_nx = 1'b0;
        end else begin
          w_hold_nx = r_hold - DW'(1);
        end
      end

      default: begin
        w_state_nx = S_IDLE;
        {w_min_u_nx, w_sec_t_nx, w_sec_u_nx} = '0;
        w_clr_n_nx = 1'b0;
      end
    endcase
  end

  // NOTE: state and outputs update with non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state  <= S_IDLE;
      r_sec_u  <= '0;
      r_sec_t  <= '0;
      r_min_u  <= '0;
      r_pre    <= PRE_MAX;
      r_hold   <= '0;
      r_load_n <= 1'b1;
      r_clr_n  <= 1'b0;
      r_en     <= 1'b0;
      r_mag    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_sec_u  <= w_sec_u_nx;
      r_sec_t  <= w_sec_t_nx;
      r_min_u  <= w_min_u_nx;
      r_pre    <= w_pre_nx;
      r_hold   <= w_hold_nx;
      r_load_n <= (w_state_nx != S_LOAD);
      r_clr_n  <= w_clr_n_nx;
      r_en     <= w_en_nx;
      r_mag    <= (w_state_nx == S_COOK) && door_closed;
      r_done   <= (w_state_nx == S_DONE);
    end
  end

  assign tmr_load_n = r_load_n;
  assign tmr_clr_n  = r_clr_n;
  assign tmr_en     = r_en;
  assign sec_u      = r_sec_u;
  assign sec_t      = r_sec_t;
  assign min_u      = r_min_u;
  assign mag_on     = r_mag;
  assign done       = r_done;
  assign state      = r_state;

endmodule
